// File: rtl/tiny5_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : tiny5_mem_arbiter_if
//  Description : Bundles the fetch requester, data requester and shared memory
//                port signals of tiny5_mem_arbiter. Names carry the arbiter's
//                point of view (_i = into the arbiter, _o = out of it).
//  Revision    : 1.0 - initial release
// ============================================================================
interface tiny5_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32
);
    // Instruction-fetch requester
    logic                  if_req_i;
    logic [ADDR_WIDTH-1:0] if_addr_i;
    logic                  if_ack_o;
    logic [31:0]           if_rdata_o;

    // Load/store requester
    logic                  d_req_i;
    logic                  d_we_i;
    logic [ADDR_WIDTH-1:0] d_addr_i;
    logic [1:0]            d_size_i;
    logic [31:0]           d_wdata_i;
    logic                  d_ack_o;
    logic                  d_err_o;
    logic [31:0]           d_rdata_o;

    // Shared memory port
    logic                  mem_valid_o;
    logic                  mem_we_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [3:0]            mem_be_o;
    logic [31:0]           mem_wdata_o;
    logic                  mem_ready_i;
    logic [31:0]           mem_rdata_i;

    // Arbiter side
    modport slave (
        input  if_req_i, if_addr_i,
        input  d_req_i, d_we_i, d_addr_i, d_size_i, d_wdata_i,
        input  mem_ready_i, mem_rdata_i,
        output if_ack_o, if_rdata_o,
        output d_ack_o, d_err_o, d_rdata_o,
        output mem_valid_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o
    );

    // Environment side (requesters plus memory)
    modport master (
        output if_req_i, if_addr_i,
        output d_req_i, d_we_i, d_addr_i, d_size_i, d_wdata_i,
        output mem_ready_i, mem_rdata_i,
        input  if_ack_o, if_rdata_o,
        input  d_ack_o, d_err_o, d_rdata_o,
        input  mem_valid_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o
    );
endinterface
`default_nettype wire

// File: rtl/tiny5_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tiny5_mem_arbiter
//  Description : Shares the single tiny5 memory port between instruction fetch
//                and load/store. One transaction at a time, round-robin on
//                ties, byte-lane steering, read right-alignment (zero-extend)
//                and immediate rejection of misaligned data accesses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tiny5_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  wire logic            clk_i,
    input  wire logic            reset_i,
    tiny5_mem_arbiter_if.slave   bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    logic [1:0]            state_q,      state_d;
    logic                  last_grant_q, last_grant_d;   // 0 = fetch, 1 = data
    logic [ADDR_WIDTH-1:0] addr_q,       addr_d;
    logic                  we_q,         we_d;
    logic [1:0]            size_q,       size_d;
    logic [DATA_WIDTH-1:0] wdata_q,      wdata_d;
    logic [3:0]            be_q,         be_d;
    // Low for the first cycle after reset release so no grant (and no
    // combinational misalignment ack) can appear in that cycle.
    logic                  armed_q;

    logic [1:0]            d_size_eff;
    logic [1:0]            d_off;
    logic [3:0]            d_be;
    logic [DATA_WIDTH-1:0] d_wdata_lane;
    logic                  d_misaligned;
    logic                  grant_d;
    logic                  grant_f;
    logic [DATA_WIDTH-1:0] rd_shift;
    logic [DATA_WIDTH-1:0] rd_aligned;
    logic                  if_ack;
    logic                  d_ack;
    logic                  d_err;
    logic [DATA_WIDTH-1:0] if_rdata;
    logic [DATA_WIDTH-1:0] d_rdata;
    logic                  mem_valid;

    // Decode the data request: lane enables, replicated store data, alignment
    always_comb begin
        d_size_eff   = (bus.d_size_i == 2'd3) ? SZ_WORD : bus.d_size_i;
        d_off        = bus.d_addr_i[1:0];
        d_be         = 4'b1111;
        d_wdata_lane = bus.d_wdata_i;
        d_misaligned = 1'b0;
        case (d_size_eff)
            SZ_BYTE: begin
                d_be         = 4'b0001 << d_off;
                d_wdata_lane = {4{bus.d_wdata_i[7:0]}};
            end
            SZ_HALF: begin
                d_be         = 4'b0011 << d_off;
                d_wdata_lane = {2{bus.d_wdata_i[15:0]}};
                d_misaligned = d_off[0];
            end
            default: begin
                d_misaligned = (d_off != 2'b00);
            end
        endcase
    end

    // Round-robin tie break: on contention the side not served last wins
    always_comb begin
        grant_d = bus.d_req_i  & (~bus.if_req_i | ~last_grant_q);
        grant_f = bus.if_req_i & (~bus.d_req_i  |  last_grant_q);
    end

    // Right-align the returned word according to the latched size/offset
    always_comb begin
        rd_shift = bus.mem_rdata_i >> {addr_q[1:0], 3'b000};
        case (size_q)
            SZ_BYTE: rd_aligned = {24'b0, rd_shift[7:0]};
            SZ_HALF: rd_aligned = {16'b0, rd_shift[15:0]};
            default: rd_aligned = rd_shift;
        endcase
    end

    // Transaction sequencer: arbitrate in IDLE, hold the request until ready
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        we_d         = we_q;
        size_d       = size_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        if_ack       = 1'b0;
        d_ack        = 1'b0;
        d_err        = 1'b0;
        if_rdata     = '0;
        d_rdata      = '0;
        case (state_q)
            S_IDLE: begin
                if (armed_q && grant_d) begin
                    last_grant_d = 1'b1;
                    if (d_misaligned) begin
                        // Rejected without a memory cycle
                        d_ack = 1'b1;
                        d_err = 1'b1;
                    end else begin
                        addr_d  = bus.d_addr_i;
                        we_d    = bus.d_we_i;
                        size_d  = d_size_eff;
                        wdata_d = d_wdata_lane;
                        be_d    = d_be;
                        state_d = S_DATA;
                    end
                end else if (armed_q && grant_f) begin
                    last_grant_d = 1'b0;
                    addr_d       = bus.if_addr_i;
                    we_d         = 1'b0;
                    size_d       = SZ_WORD;
                    wdata_d      = '0;
                    be_d         = 4'b1111;
                    state_d      = S_FETCH;
                end
            end
            S_FETCH: begin
                if (bus.mem_ready_i) begin
                    if_ack   = 1'b1;
                    if_rdata = bus.mem_rdata_i;
                    state_d  = S_IDLE;
                end
            end
            S_DATA: begin
                if (bus.mem_ready_i) begin
                    d_ack   = 1'b1;
                    d_rdata = rd_aligned;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and latched request; reset abandons any transaction in flight
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            size_q       <= 2'b00;
            wdata_q      <= '0;
            be_q         <= 4'b0000;
            armed_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            size_q       <= size_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            armed_q      <= 1'b1;
        end
    end

    assign mem_valid       = (state_q != S_IDLE);
    assign bus.mem_valid_o = mem_valid;
    assign bus.mem_we_o    = mem_valid & we_q;
    assign bus.mem_addr_o  = mem_valid ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
    assign bus.mem_be_o    = mem_valid ? be_q : 4'b0000;
    assign bus.mem_wdata_o = mem_valid ? wdata_q : '0;
    assign bus.if_ack_o    = if_ack;
    assign bus.if_rdata_o  = if_rdata;
    assign bus.d_ack_o     = d_ack;
    assign bus.d_err_o     = d_err;
    assign bus.d_rdata_o   = d_rdata;

endmodule
`default_nettype wire

// File: doc/tiny5_mem_arbiter.md
Name: tiny5_mem_arbiter

Overview:
- Shares the single tiny5 memory port between the instruction-fetch requester (PC) and the load/store requester (ALU_OUT address).
- Sequences one transaction at a time. Generates byte enables and write-data lane replication from mem_access_size_t. Right-aligns read data, zero-extended; sign extension stays in the regfile input mux.
- Rejects misaligned data accesses without touching memory.

Parameters:
- ADDR_WIDTH, 32, width of all address ports.
- DATA_WIDTH, 32, width of data ports; fixed at 32, with 4 byte lanes.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous, active-high reset
- if_req_i  in  1  fetch request; held until if_ack_o
- if_addr_i  in  ADDR_WIDTH  fetch address; always a word access
- if_ack_o  out  1  fetch completion pulse
- if_rdata_o  out  32  fetched instruction; valid with if_ack_o
- d_req_i  in  1  data request; held until d_ack_o
- d_we_i  in  1  1 = store, 0 = load
- d_addr_i  in  ADDR_WIDTH  data address
- d_size_i  in  2  mem_access_size_t (BYTE=0, HALF=1, WORD=2)
- d_wdata_i  in  32  store data, right-aligned
- d_ack_o  out  1  data completion pulse
- d_err_o  out  1  misaligned-access error; valid with d_ack_o
- d_rdata_o  out  32  load data, right-aligned, zero-extended
- mem_valid_o  out  1  memory request valid
- mem_we_o  out  1  memory write
- mem_addr_o  out  ADDR_WIDTH  word-aligned address (bits [1:0] = 0)
- mem_be_o  out  4  byte enables
- mem_wdata_o  out  32  lane-replicated write data
- mem_ready_i  in  1  memory completes the current request; mem_rdata_i valid this cycle
- mem_rdata_i  in  32  memory read word

Behaviour:
- State machine IDLE / FETCH / DATA. Registers:
  - state
  - last_grant (0 = fetch, 1 = data)
  - latched request: addr, we, size, wdata, be
- Reset: asynchronous, active-high.
  - state = IDLE, last_grant = 0, all latched fields = 0.
  - Every output is 0 while reset_i is high, and the first cycle after release.
  - Reset mid-transaction abandons the transaction: mem_valid_o drops immediately and no ack is issued.
- IDLE arbitration:
  - Only one requester active → grant it.
  - Both active → grant the one not in last_grant. After reset the data side therefore wins the first tie.
  - On grant: latch fields, update last_grant, go to FETCH or DATA.
- Misaligned data access in IDLE, when the data side is granted:
  - HALF with addr[0] = 1, or WORD with addr[1:0] ≠ 0.
  - d_ack_o = 1 and d_err_o = 1 combinationally in that same cycle.
  - No memory access; state stays IDLE; last_grant is updated.
- FETCH and DATA states:
  - mem_valid_o = 1 with the latched fields, held stable until mem_ready_i.
  - Latency: request granted in cycle N → mem_valid_o first high in cycle N+1.
- Completion, in the cycle mem_ready_i = 1:
  - The owning ack_o is 1 combinationally, rdata_o = aligned mem_rdata_i, and the next state is IDLE.
  - The requester must drop or replace its req by the next cycle; a req still high in IDLE is treated as a new request.
- Minimum spacing:
  - Two back-to-back transactions are separated by one IDLE cycle.
  - Zero-wait memory gives 2 cycles per access.
- Byte enables and write data, with o = addr[1:0]:
  - BYTE: be = 4'b0001 << o; wdata = {4{wdata[7:0]}}.
  - HALF: be = 4'b0011 << o; wdata = {2{wdata[15:0]}}.
  - WORD: be = 4'b1111; wdata unchanged.
  - Fetch: be = 4'b1111, we = 0.
- Read alignment: shifted = mem_rdata_i >> (8*o).
  - BYTE → {24'b0, shifted[7:0]}.
  - HALF → {16'b0, shifted[15:0]}.
  - WORD → mem_rdata_i.
- ack / err / rdata outputs are 0 whenever their ack is not asserted.
- Input changes on the non-granted side have no effect until IDLE.
- d_size_i = 3 is reserved and treated as WORD.

Test Plan:
- Fetch alone, memory ready on the 1st valid cycle:
  - if_addr_i = 0x100, mem_rdata_i = 0x00500093.
  - → mem_valid_o high exactly 1 cycle with mem_addr_o = 0x100, be = 4'hF.
  - → if_ack_o in the same cycle with if_rdata_o = 0x00500093.
- Store byte to 0x203 with d_wdata_i = 0x000000AB:
  - → mem_addr_o = 0x200, mem_be_o = 4'b1000, mem_wdata_o = 0xABABABAB, mem_we_o = 1.
- Load half from 0x202 with mem_rdata_i = 0xBEEF1234, ready after 3 wait cycles:
  - → mem_valid_o stable for 4 cycles.
  - → d_rdata_o = 0x0000BEEF on d_ack_o.
- Word load from 0x206:
  - → d_ack_o = 1 and d_err_o = 1 in the grant cycle, mem_valid_o never asserted.
  - Half load from 0x205 gives the same result.
- Both requests held high continuously, zero-wait memory:
  - → grants alternate data, fetch, data, fetch.
  - → one ack every 2 cycles, and neither side waits more than one transaction.
- reset_i asserted while in DATA with mem_valid_o high:
  - → mem_valid_o drops asynchronously and no ack is issued.
  - → after release, the first tie is granted to the data side.
